// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with parallel load, enable prescaler,
// and registered step / terminal-count pulses plus a sticky overflow flag.
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             tc,
  output logic             overflow
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [XW-1:0]    Q_MAX_X = XW'(MODULUS - 1);
  localparam logic [PW-1:0]    P_MAX   = PW'(PRESCALE - 1);

  logic [PW-1:0]    pcnt;
  logic             step_c;
  logic             wrap_c;
  logic [WIDTH-1:0] q_step_c;
  logic [WIDTH-1:0] load_q_c;

  // Next-count arithmetic; the extended compare keeps the clamp right when MODULUS == 2**WIDTH.
  always_comb begin
    step_c   = enable && (pcnt == P_MAX);
    wrap_c   = 1'b0;
    q_step_c = q;
    load_q_c = ({1'b0, load_value} > Q_MAX_X) ? Q_MAX : load_value;
    if (up_down) begin
      wrap_c   = (q == Q_MAX);
      q_step_c = wrap_c ? '0 : q + WIDTH'(1);
    end else begin
      wrap_c   = (q == '0);
      q_step_c = wrap_c ? Q_MAX : q - WIDTH'(1);
    end
  end

  // Count, prescaler and flag registers; priority clear > load > step.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q        <= '0;
      pcnt     <= '0;
      step     <= 1'b0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      q    <= load_q_c;
      pcnt <= '0;
      step <= 1'b0;
      tc   <= 1'b0;
      if (ovf_clr) overflow <= 1'b0;
    end else begin
      step <= step_c;
      tc   <= step_c && wrap_c;
      if (enable) pcnt <= step_c ? '0 : pcnt + PW'(1);
      if (step_c) q <= q_step_c;
      if (step_c && wrap_c) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: dut_a (MODULUS=10, PRESCALE=1) and dut_b (MODULUS=10, PRESCALE=4).
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_clear, a_enable, a_up_down, a_load, a_ovf_clr;
  logic [7:0] a_load_value;
  logic [7:0] a_q;
  logic       a_step, a_tc, a_overflow;

  logic       b_clear, b_enable, b_up_down, b_load, b_ovf_clr;
  logic [7:0] b_load_value;
  logic [7:0] b_q;
  logic       b_step, b_tc, b_overflow;

  int n_checks = 0;
  int n_errors = 0;

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .clear(a_clear), .enable(a_enable), .up_down(a_up_down),
    .load(a_load), .load_value(a_load_value), .ovf_clr(a_ovf_clr),
    .q(a_q), .step(a_step), .tc(a_tc), .overflow(a_overflow)
  );

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4)) dut_b (
    .clk(clk), .clear(b_clear), .enable(b_enable), .up_down(b_up_down),
    .load(b_load), .load_value(b_load_value), .ovf_clr(b_ovf_clr),
    .q(b_q), .step(b_step), .tc(b_tc), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_clear = 1'b1; a_enable = 1'b0; a_up_down = 1'b1; a_load = 1'b0;
    a_load_value = 8'd0; a_ovf_clr = 1'b0;
    b_clear = 1'b1; b_enable = 1'b0; b_up_down = 1'b1; b_load = 1'b0;
    b_load_value = 8'd0; b_ovf_clr = 1'b0;

    // Reset state while clear is held across an edge
    #12;
    chk("a_rst_q", 32'(a_q), 0);
    chk("a_rst_step", 32'(a_step), 0);
    chk("a_rst_tc", 32'(a_tc), 0);
    chk("a_rst_ovf", 32'(a_overflow), 0);

    // Test 1: count up 12 steps from 0, wrap at 10
    a_clear = 1'b0; a_enable = 1'b1; a_up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("t1_q_%0d", i), 32'(a_q), 32'(i % 10));
      chk($sformatf("t1_tc_%0d", i), 32'(a_tc), (i == 10) ? 32'd1 : 32'd0);
      chk($sformatf("t1_step_%0d", i), 32'(a_step), 1);
    end
    chk("t1_ovf", 32'(a_overflow), 1);

    // Test 2: load 0, then count down through the wrap
    a_load = 1'b1; a_load_value = 8'd0; a_up_down = 1'b0;
    tick();
    chk("t2_load_q", 32'(a_q), 0);
    chk("t2_load_step", 32'(a_step), 0);
    a_load = 1'b0;
    tick();
    chk("t2_q9", 32'(a_q), 9);
    chk("t2_tc9", 32'(a_tc), 1);
    tick();
    chk("t2_q8", 32'(a_q), 8);
    chk("t2_tc8", 32'(a_tc), 0);
    chk("t2_step8", 32'(a_step), 1);

    // Test 6b: ovf_clr on a non-wrap edge clears overflow
    a_ovf_clr = 1'b1;
    tick();
    chk("t6_q7", 32'(a_q), 7);
    chk("t6_ovf_cleared", 32'(a_overflow), 0);
    a_ovf_clr = 1'b0;

    // Test 6a: ovf_clr on the same edge as a wrap keeps overflow set
    a_enable = 1'b0; a_load = 1'b1; a_load_value = 8'd0;
    tick();
    chk("t6_load0", 32'(a_q), 0);
    a_load = 1'b0; a_enable = 1'b1; a_ovf_clr = 1'b1;
    tick();
    chk("t6_wrap_q", 32'(a_q), 9);
    chk("t6_wrap_tc", 32'(a_tc), 1);
    chk("t6_wrap_ovf", 32'(a_overflow), 1);
    a_ovf_clr = 1'b0; a_enable = 1'b0;

    // Test 3: load clamp and load beating enable
    a_load = 1'b1; a_load_value = 8'd200;
    tick();
    chk("t3_clamp_q", 32'(a_q), 9);
    chk("t3_clamp_step", 32'(a_step), 0);
    a_load_value = 8'd5; a_enable = 1'b1; a_up_down = 1'b1;
    tick();
    chk("t3_load5_q", 32'(a_q), 5);
    chk("t3_load5_step", 32'(a_step), 0);
    chk("t3_load5_tc", 32'(a_tc), 0);
    a_load = 1'b0; a_enable = 1'b0;
    tick();
    chk("t3_hold_q", 32'(a_q), 5);

    // Test 4: prescaler of 4 on dut_b
    b_clear = 1'b0; b_enable = 1'b1; b_up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("t4_q_%0d", i), 32'(b_q), 32'(i / 4));
      chk($sformatf("t4_step_%0d", i), 32'(b_step), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    tick(); tick();
    chk("t4_partial_q", 32'(b_q), 3);
    b_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_frozen_q_%0d", i), 32'(b_q), 3);
      chk($sformatf("t4_frozen_step_%0d", i), 32'(b_step), 0);
    end
    b_enable = 1'b1;
    tick();
    chk("t4_resume1_step", 32'(b_step), 0);
    chk("t4_resume1_q", 32'(b_q), 3);
    tick();
    chk("t4_resume2_step", 32'(b_step), 1);
    chk("t4_resume2_q", 32'(b_q), 4);

    // Test 5: build overflow, go to q=7 mid-prescale, then clear asynchronously
    b_load = 1'b1; b_load_value = 8'd9;
    tick();
    b_load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_wrap_q", 32'(b_q), 0);
    chk("t5_wrap_tc", 32'(b_tc), 1);
    chk("t5_ovf_set", 32'(b_overflow), 1);
    b_load = 1'b1; b_load_value = 8'd7;
    tick();
    b_load = 1'b0;
    tick(); tick();
    chk("t5_pre_q", 32'(b_q), 7);
    #2 b_clear = 1'b1;
    #1;
    chk("t5_async_q", 32'(b_q), 0);
    chk("t5_async_ovf", 32'(b_overflow), 0);
    chk("t5_async_step", 32'(b_step), 0);
    chk("t5_async_tc", 32'(b_tc), 0);
    tick();
    chk("t5_held_q", 32'(b_q), 0);
    b_clear = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t5_restart_q_%0d", i), 32'(b_q), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t5_restart_step_%0d", i), 32'(b_step), (i == 4) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
